crc_key_hasher: RTL and testbench



---
 rtl/crc_key_hasher_pkg.sv | 16 +
 rtl/crc32_step64.sv | 21 ++
 rtl/crc_key_hasher.sv | 96 +++++++++
 tb/tb_crc_key_hasher.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_key_hasher_pkg.sv
// Shared constants and result type for the flow-key CRC hashing stage
// and the later multi-hash stages that reuse its CRC step.
package crc_key_hasher_pkg;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam int          KEY_W    = 64;
  localparam int          HASH_W   = 32;
  localparam int          BEAT_W   = 8;

  typedef struct packed {
    logic [HASH_W-1:0] hash;
    logic [BEAT_W-1:0] beats;
    logic              trunc;
  } result_t;

endpackage

// File: rtl/crc32_step64.sv
// Combinational CRC-32 (poly 0x04C11DB7, non-reflected) advance over one
// 64-bit word, MSB first. Seed-agnostic so other hash lanes can reuse it.
module crc32_step64
  import crc_key_hasher_pkg::*;
(
  input  logic [HASH_W-1:0] crc_in,
  input  logic [KEY_W-1:0]  data,
  output logic [HASH_W-1:0] crc_out
);

  logic [HASH_W-1:0] acc;

  always_comb begin
    acc = crc_in;
    for (int i = KEY_W - 1; i >= 0; i--) begin
      acc = {acc[HASH_W-2:0], 1'b0} ^ ({HASH_W{acc[HASH_W-1] ^ data[i]}} & CRC_POLY);
    end
    crc_out = acc;
  end

endmodule

// File: rtl/crc_key_hasher.sv
// Folds multi-beat flow keys into a CRC-32 and presents one hash/bucket
// result per key on a valid/ready output register; over-long keys are capped.
module crc_key_hasher
  import crc_key_hasher_pkg::*;
#(
  parameter logic [31:0] SEED      = 32'h0000_0000,
  parameter logic [31:0] XOROUT    = 32'h0000_0000,
  parameter int          IDX_W     = 16,
  parameter int          MAX_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [63:0]       s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       m_hash,
  output logic [IDX_W-1:0]  m_index,
  output logic [7:0]        m_beats,
  output logic              m_trunc
);

  logic [HASH_W-1:0] crc_q, crc_d, crc_next;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              drop_q, drop_d;
  logic              m_valid_q, m_valid_d;
  result_t           res_q, res_d;

  logic              accept;
  logic              at_cap;
  logic [BEAT_W:0]   beat_inc;

  crc32_step64 u_step (
    .crc_in  (crc_q),
    .data    (s_data),
    .crc_out (crc_next)
  );

  // An un-drained result blocks input; a draining one frees the slot this cycle.
  assign s_ready  = !(m_valid_q && !m_ready);
  assign accept   = s_valid && s_ready;
  assign beat_inc = {1'b0, beat_cnt_q} + 9'd1;
  assign at_cap   = (beat_inc == 9'(MAX_BEATS));

  always_comb begin
    crc_d      = crc_q;
    beat_cnt_d = beat_cnt_q;
    drop_d     = drop_q;
    m_valid_d  = m_valid_q;
    res_d      = res_q;

    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    if (accept) begin
      if (drop_q) begin
        if (s_last) drop_d = 1'b0;
      end else if (s_last || at_cap) begin
        res_d.hash  = crc_next ^ XOROUT;
        res_d.beats = beat_inc[BEAT_W-1:0];
        res_d.trunc = !s_last;
        drop_d      = !s_last;
        m_valid_d   = 1'b1;
        crc_d       = SEED;
        beat_cnt_d  = '0;
      end else begin
        crc_d      = crc_next;
        beat_cnt_d = beat_inc[BEAT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q      <= SEED;
      beat_cnt_q <= '0;
      drop_q     <= 1'b0;
      m_valid_q  <= 1'b0;
      res_q      <= '0;
    end else begin
      crc_q      <= crc_d;
      beat_cnt_q <= beat_cnt_d;
      drop_q     <= drop_d;
      m_valid_q  <= m_valid_d;
      res_q      <= res_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_hash  = res_q.hash;
  assign m_index = res_q.hash[IDX_W-1:0];
  assign m_beats = res_q.beats;
  assign m_trunc = res_q.trunc;

endmodule

// File: tb/tb_crc_key_hasher.sv
// Bench for crc_key_hasher: directed cases plus random streaming against a
// polynomial long-division CRC model and an in-order result scoreboard.
module tb_crc_key_hasher;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_hash;
  logic [15:0] m_index;
  logic [7:0]  m_beats;
  logic        m_trunc;

  crc_key_hasher #(
    .SEED(32'h0), .XOROUT(32'h0), .IDX_W(16), .MAX_BEATS(MAXB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_hash(m_hash), .m_index(m_index), .m_beats(m_beats), .m_trunc(m_trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] h;
    logic [7:0]  b;
    logic        t;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] key_buf [0:15];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_rx     = 0;
  int          n_pushed = 0;
  int          ready_mode = 1;  // 0: hold off, 1: always ready, 2: random
  bit          gap_en = 0;
  longint      cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // CRC as remainder of (message * x^32) mod P, by long division.
  function automatic logic [31:0] ref_hash(input int n);
    logic [32:0] r;
    r = '0;
    for (int k = 0; k < n + 1; k++) begin
      for (int i = 63; i >= 0; i--) begin
        if (k == n && i < 32) break;
        r = {r[31:0], (k < n) ? key_buf[k][i] : 1'b0};
        if (r[32]) r = r ^ {1'b1, 32'h04C11DB7};
      end
    end
    return r[31:0];
  endfunction

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      n_rx++;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'(m_hash), 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_hash",  64'(m_hash),  64'(e.h));
        chk("sb_index", 64'(m_index), 64'(e.h[15:0]));
        chk("sb_beats", 64'(m_beats), 64'(e.b));
        chk("sb_trunc", 64'(m_trunc), 64'(e.t));
      end
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    $display("FAIL send_beat_timeout observed=stalled expected=accepted");
    $fatal(1, "input stalled");
  endtask

  task automatic push_exp(input int len);
    exp_t e;
    int   n;
    n   = (len > MAXB) ? MAXB : len;
    e.h = ref_hash(n);
    e.b = 8'(n);
    e.t = (len > MAXB);
    exp_q.push_back(e);
    n_pushed++;
  endtask

  task automatic send_key(input int len);
    for (int k = 0; k < len; k++) key_buf[k] = {$urandom, $urandom};
    push_exp(len);
    for (int k = 0; k < len; k++) begin
      if (gap_en && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        s_data  = {$urandom, $urandom};
        s_last  = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      send_beat(key_buf[k], k == len - 1);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 500; t++) begin
      if (exp_q.size() == 0 && !m_valid) return;
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'h0);
  endtask

  initial begin
    logic [63:0] d0;
    longint      t0;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'h0);
    chk("rst_m_hash",  64'(m_hash),  64'h0);
    chk("rst_m_index", 64'(m_index), 64'h0);
    chk("rst_m_beats", 64'(m_beats), 64'h0);
    chk("rst_m_trunc", 64'(m_trunc), 64'h0);
    chk("rst_s_ready", 64'(s_ready), 64'h1);
    @(posedge clk);
    #1;

    // Single beat of 1 gives the polynomial itself.
    key_buf[0] = 64'h1;
    push_exp(1);
    send_beat(64'h1, 1'b1);
    s_valid = 1'b0;
    chk("one_valid", 64'(m_valid), 64'h1);
    chk("one_hash",  64'(m_hash),  64'h04C11DB7);
    chk("one_index", 64'(m_index), 64'h1DB7);
    chk("one_beats", 64'(m_beats), 64'h1);
    chk("one_trunc", 64'(m_trunc), 64'h0);

    key_buf[0] = 64'h0;
    push_exp(1);
    send_beat(64'h0, 1'b1);
    chk("zero_hash", 64'(m_hash), 64'h0);
    key_buf[0] = 64'h0;
    key_buf[1] = 64'h1;
    push_exp(2);
    send_beat(64'h0, 1'b0);
    send_beat(64'h1, 1'b1);
    s_valid = 1'b0;
    chk("zpfx_hash",  64'(m_hash),  64'h04C11DB7);
    chk("zpfx_beats", 64'(m_beats), 64'h2);
    drain();

    // Back-pressure: held result stalls input and stays stable.
    ready_mode = 0;
    @(posedge clk);
    #1;
    send_key(1);
    s_valid = 1'b1;
    s_data  = {$urandom, $urandom};
    s_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_s_ready", 64'(s_ready), 64'h0);
      chk("bp_m_valid", 64'(m_valid), 64'h1);
      chk("bp_hold_hash", 64'(m_hash), 64'(exp_q[0].h));
      @(posedge clk);
      #1;
    end
    ready_mode = 1;
    for (int k = 0; k < 3; k++) send_key(1 + k);
    s_valid = 1'b0;
    drain();

    // Truncation at the cap, then a clean key.
    send_key(6);
    send_key(2);
    s_valid = 1'b0;
    drain();

    // Reset in the middle of a key.
    send_beat({$urandom, $urandom}, 1'b0);
    send_beat({$urandom, $urandom}, 1'b0);
    s_valid = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_mid_valid", 64'(m_valid), 64'h0);
    key_buf[0] = 64'h1;
    push_exp(1);
    send_beat(64'h1, 1'b1);
    s_valid = 1'b0;
    chk("rst_mid_hash", 64'(m_hash), 64'h04C11DB7);
    drain();

    // Back-to-back single-beat keys: one result per cycle.
    t0 = cyc;
    for (int k = 0; k < 20; k++) send_key(1);
    s_valid = 1'b0;
    chk("throughput_cycles", 64'(cyc - t0), 64'd20);
    drain();

    // Random streaming with random back-pressure and input gaps.
    ready_mode = 2;
    gap_en     = 1;
    for (int k = 0; k < 1000; k++) send_key($urandom_range(1, 4));
    s_valid    = 1'b0;
    ready_mode = 1;
    drain();
    chk("rx_count", 64'(n_rx), 64'(n_pushed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
